// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory: FSM state encoding,
// wait-counter width and the address range check.
package mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_state_e;

  localparam int WAIT_CNT_W = 3;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one combinational
// read port, no reset (contents are cleared by the fill sequencer instead).
module mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_memory.sv
// Single-port data memory with valid/ready request port, one-cycle response
// pulse, configurable wait states, range checking and post-reset zero fill.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE. rsp_valid is a single-cycle pulse without
// backpressure; rsp_rdata/rsp_error are meaningful only while rsp_valid is high.
module data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int WAIT_STATES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam mem_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  mem_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;

  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    in_range;

  assign in_range = addr_in_range(32'(req_addr), DEPTH);

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (req_addr[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    mem_we      = 1'b0;
    mem_waddr   = req_addr[IDX_W-1:0];
    mem_wdata   = req_wdata;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q[IDX_W-1:0];
        mem_wdata = '0;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (req_valid) begin
          // Read and write share the accept edge, so a write reports the old word.
          rsp_rdata_d = in_range ? mem_rdata : '0;
          rsp_error_d = !in_range;
          mem_we      = req_write && in_range;
          wait_cnt_d  = '0;
          state_d     = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q == CLEAR);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign dbg_state = state_q;

endmodule
